// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if
//   Bundles the game-FSM strobes, the mute switch and the tone-generator
//   outputs of the tone sequencer.
//   master : game side, drives win/lose/mute and observes the outputs
//   slave  : sequencer side, samples win/lose/mute and drives the outputs
interface tone_sequencer_if;
    logic       win;
    logic       lose;
    logic       mute;
    logic [9:0] sound_freq_out;
    logic       enable_sound;
    logic       busy;
    logic       done;

    modport master (
        output win, lose, mute,
        input  sound_freq_out, enable_sound, busy, done
    );

    modport slave (
        input  win, lose, mute,
        output sound_freq_out, enable_sound, busy, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a short win or lose jingle on the board tone generator when the
//   game FSM strobes win or lose. Lose has priority and may pre-empt a
//   running win jingle. All outputs are registered.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   tone   : slave side of tone_sequencer_if
//            win/lose (1-cycle strobes), mute (level),
//            sound_freq_out[9:0], enable_sound, busy, done
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | silent, waiting for a win/lose strobe
// S_NOTE   | current note sounding for NOTE_TICKS cycles
// S_GAP    | silence after a note for GAP_TICKS cycles
// S_FINISH | one-cycle done pulse, then back to S_IDLE
module tone_sequencer #(
    parameter int NOTE_TICKS = 5,
    parameter int GAP_TICKS  = 2,
    parameter int WIN_LEN    = 4,
    parameter int LOSE_LEN   = 3
) (
    input  logic             clk,
    input  logic             resetN,
    tone_sequencer_if.slave  tone
);

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS)
                             ? ((NOTE_TICKS > 2) ? NOTE_TICKS : 2)
                             : ((GAP_TICKS  > 2) ? GAP_TICKS  : 2);
    localparam int CW = $clog2(MAX_TICKS);

    localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;
    localparam logic [1:0]    WIN_LAST  = 2'(WIN_LEN - 1);
    localparam logic [1:0]    LOSE_LAST = 2'(LOSE_LEN - 1);

    localparam logic SEL_WIN  = 1'b0;
    localparam logic SEL_LOSE = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP, S_FINISH} state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    freq_q, freq_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          start;
    logic          start_sel;
    logic [1:0]    last_idx;

    function automatic logic [9:0] rom_note(input logic sel, input logic [1:0] idx);
        logic [9:0] f;
        f = '0;
        case ({sel, idx})
            3'b000: f = 10'd5;
            3'b001: f = 10'd7;
            3'b010: f = 10'd9;
            3'b011: f = 10'd12;
            3'b100: f = 10'd9;
            3'b101: f = 10'd7;
            3'b110: f = 10'd5;
            3'b111: f = 10'd2;
        endcase
        return f;
    endfunction

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        start_sel = SEL_WIN;
        last_idx  = (sel_q == SEL_LOSE) ? LOSE_LAST : WIN_LAST;

        case (state_q)
            S_IDLE: begin
                if (tone.lose) begin
                    start     = 1'b1;
                    start_sel = SEL_LOSE;
                end else if (tone.win) begin
                    start     = 1'b1;
                    start_sel = SEL_WIN;
                end
            end
            S_NOTE, S_GAP: begin
                // only lose can interrupt, and only a win jingle
                if (tone.lose && (sel_q == SEL_WIN)) begin
                    start     = 1'b1;
                    start_sel = SEL_LOSE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if ((state_q == S_NOTE) && (GAP_TICKS > 0)) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else if (idx_q == last_idx) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_NOTE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = NOTE_LOAD;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_NOTE;
            sel_d   = start_sel;
            idx_d   = 2'd0;
            cnt_d   = NOTE_LOAD;
        end

        // outputs follow the next state so they are valid the cycle after the edge
        freq_d = (state_d == S_NOTE) ? rom_note(sel_d, idx_d) : 10'd0;
        en_d   = (state_d == S_NOTE) && !tone.mute;
        busy_d = (state_d == S_NOTE) || (state_d == S_GAP);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_WIN;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            freq_q  <= 10'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tone.sound_freq_out = freq_q;
    assign tone.enable_sound   = en_q;
    assign tone.busy           = busy_q;
    assign tone.done           = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    logic clk = 1'b0;
    logic resetN;

    tone_sequencer_if sif ();
    tone_sequencer_if sif2 ();

    tone_sequencer dut1 (
        .clk    (clk),
        .resetN (resetN),
        .tone   (sif)
    );

    tone_sequencer #(
        .NOTE_TICKS (1),
        .GAP_TICKS  (0),
        .WIN_LEN    (2),
        .LOSE_LEN   (3)
    ) dut2 (
        .clk    (clk),
        .resetN (resetN),
        .tone   (sif2)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    // model: a melody is described only by its start cycle and selection;
    // outputs are derived from the offset into it
    int pN [2]  = '{5, 1};
    int pG [2]  = '{2, 0};
    int pWL[2]  = '{4, 2};
    int pLL[2]  = '{3, 3};
    int rom_win [4] = '{5, 7, 9, 12};
    int rom_lose[4] = '{9, 7, 5, 2};

    int m_start[2];
    bit m_act  [2];
    bit m_sel  [2];
    bit m_mute [2];

    task automatic chk(input string nm, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic int mel_len(input int i);
        return m_sel[i] ? pLL[i] : pWL[i];
    endfunction

    // 0 idle, 1 busy, 2 finish
    function automatic int phase(input int i, input int c);
        int k;
        int tot;
        if (!m_act[i]) return 0;
        k   = c - m_start[i] - 1;
        tot = mel_len(i) * (pN[i] + pG[i]);
        if (k >= 0 && k < tot) return 1;
        if (k == tot) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge resetN) begin
        bit w[2];
        bit l[2];
        bit mu[2];
        int ph;
        if (!resetN) begin
            m_act[0] = 1'b0;
            m_act[1] = 1'b0;
        end else begin
            w[0] = sif.win;   l[0] = sif.lose;   mu[0] = sif.mute;
            w[1] = sif2.win;  l[1] = sif2.lose;  mu[1] = sif2.mute;
            for (int i = 0; i < 2; i++) begin
                ph = phase(i, cyc);
                if ((ph == 0 && (l[i] || w[i])) || (ph == 1 && l[i] && !m_sel[i])) begin
                    m_act[i]   = 1'b1;
                    m_sel[i]   = l[i];
                    m_start[i] = cyc;
                end
                m_mute[i] = mu[i];
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        int ph, k, p, ef, ee, eb, ed;
        int gf, ge, gb, gd;
        for (int i = 0; i < 2; i++) begin
            ef = 0; ee = 0; eb = 0; ed = 0;
            ph = phase(i, cyc);
            if (ph == 1) begin
                k  = cyc - m_start[i] - 1;
                p  = pN[i] + pG[i];
                eb = 1;
                if ((k % p) < pN[i]) begin
                    ef = m_sel[i] ? rom_lose[k / p] : rom_win[k / p];
                    ee = m_mute[i] ? 0 : 1;
                end
            end else if (ph == 2) begin
                ed = 1;
            end
            if (i == 0) begin
                gf = sif.sound_freq_out;  ge = sif.enable_sound;  gb = sif.busy;  gd = sif.done;
            end else begin
                gf = sif2.sound_freq_out; ge = sif2.enable_sound; gb = sif2.busy; gd = sif2.done;
            end
            chk($sformatf("dut%0d freq", i + 1), gf, ef);
            chk($sformatf("dut%0d enable", i + 1), ge, ee);
            chk($sformatf("dut%0d busy", i + 1), gb, eb);
            chk($sformatf("dut%0d done", i + 1), gd, ed);
        end
    end

    task automatic pulse(input bit w, input bit l);
        @(negedge clk);
        sif.win  = w;
        sif.lose = l;
        @(negedge clk);
        sif.win  = 1'b0;
        sif.lose = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (sif.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_done_pulse(input string nm);
        chk({nm, " done high"}, int'(sif.done), 1);
        @(negedge clk);
        chk({nm, " done low after"}, int'(sif.done), 0);
    endtask

    initial begin
        int n;
        int dones;
        resetN    = 1'b0;
        sif.win   = 1'b0; sif.lose  = 1'b0; sif.mute  = 1'b0;
        sif2.win  = 1'b0; sif2.lose = 1'b0; sif2.mute = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset freq", int'(sif.sound_freq_out), 0);
        chk("reset enable", int'(sif.enable_sound), 0);
        chk("reset busy", int'(sif.busy), 0);
        chk("reset done", int'(sif.done), 0);
        resetN = 1'b1;
        repeat (6) @(negedge clk);

        // plain win jingle
        pulse(1'b1, 1'b0);
        chk("win note0 freq", int'(sif.sound_freq_out), 5);
        chk("win note0 enable", int'(sif.enable_sound), 1);
        repeat (5) @(negedge clk);
        chk("win gap freq", int'(sif.sound_freq_out), 0);
        chk("win gap busy", int'(sif.busy), 1);
        repeat (2) @(negedge clk);
        chk("win note1 freq", int'(sif.sound_freq_out), 7);
        repeat (7) @(negedge clk);
        chk("win note2 freq", int'(sif.sound_freq_out), 9);
        repeat (7) @(negedge clk);
        chk("win note3 freq", int'(sif.sound_freq_out), 12);
        count_busy(n);
        chk("win remaining busy", n, 7);
        check_done_pulse("win");
        repeat (4) @(negedge clk);

        // simultaneous strobes: lose has priority
        pulse(1'b1, 1'b1);
        chk("both first freq", int'(sif.sound_freq_out), 9);
        count_busy(n);
        chk("both busy cycles", n, 21);
        check_done_pulse("both");
        repeat (4) @(negedge clk);

        // lose pre-empts a win while note 7 plays
        pulse(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        chk("preempt before freq", int'(sif.sound_freq_out), 7);
        sif.lose = 1'b1;
        @(negedge clk);
        sif.lose = 1'b0;
        chk("preempt freq", int'(sif.sound_freq_out), 9);
        count_busy(n);
        chk("preempt busy cycles", n, 21);
        check_done_pulse("preempt");
        repeat (4) @(negedge clk);

        // strobes during a lose jingle are ignored
        pulse(1'b0, 1'b1);
        n = 0;
        while (sif.busy && n < 200) begin
            sif.win  = (n == 3);
            sif.lose = (n == 3);
            n++;
            @(negedge clk);
        end
        sif.win  = 1'b0;
        sif.lose = 1'b0;
        chk("lose ignore busy cycles", n, 21);
        check_done_pulse("lose ignore");
        repeat (4) @(negedge clk);

        // mute keeps enable low, timing unchanged
        sif.mute = 1'b1;
        pulse(1'b1, 1'b0);
        chk("mute freq", int'(sif.sound_freq_out), 5);
        chk("mute enable", int'(sif.enable_sound), 0);
        count_busy(n);
        chk("mute busy cycles", n, 28);
        check_done_pulse("mute");
        sif.mute = 1'b0;
        repeat (4) @(negedge clk);

        // no-gap, single-tick notes, 2-note win
        sif2.win = 1'b1;
        @(negedge clk);
        sif2.win = 1'b0;
        chk("fast note0", int'(sif2.sound_freq_out), 5);
        @(negedge clk);
        chk("fast note1", int'(sif2.sound_freq_out), 7);
        chk("fast busy", int'(sif2.busy), 1);
        @(negedge clk);
        chk("fast done", int'(sif2.done), 1);
        chk("fast busy end", int'(sif2.busy), 0);
        @(negedge clk);
        chk("fast done low", int'(sif2.done), 0);
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of a note
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre-reset freq", int'(sif.sound_freq_out), 5);
        #2;
        resetN = 1'b0;
        #1;
        chk("async reset freq", int'(sif.sound_freq_out), 0);
        chk("async reset enable", int'(sif.enable_sound), 0);
        chk("async reset busy", int'(sif.busy), 0);
        chk("async reset done", int'(sif.done), 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            dones += int'(sif.done) + int'(sif.busy);
        end
        chk("post-reset activity", dones, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays short multi-note jingles on the board tone generator when the game FSM reports a win or a loss.
- Sits between the game FSM's single-cycle win/lose strobes and the tone generator's frequency-index input.
- Replaces the single fixed buzz with sequenced melodies.
- Arbitrates between win and lose requests: lose always has priority.

Parameters:
- NOTE_TICKS, 5, clock cycles each note sounds. Use 5 for simulation and 12_500_000 on board. Must be >= 1.
- GAP_TICKS, 2, silent cycles after each note. 0 is legal and means no gap.
- WIN_LEN, 4, number of notes in the win melody (1..4).
- LOSE_LEN, 3, number of notes in the lose melody (1..4).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- win  in  1  one-cycle strobe from the game FSM: start the win melody
- lose  in  1  one-cycle strobe from the game FSM: start the lose melody
- mute  in  1  level input (switch); forces enable_sound low, sequencing continues
- sound_freq_out  out  10  frequency index to the tone generator
- enable_sound  out  1  tone generator enable
- busy  out  1  high while a melody is in progress (NOTE or GAP)
- done  out  1  one-cycle pulse when a melody completes normally

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; all outputs 0; note index and tick counter 0; melody select = WIN.
  - Reset mid-melody aborts immediately. No done pulse.
- Melody ROM (10-bit indices), indexed 0..LEN-1:
  - WIN = {5, 7, 9, 12}; first WIN_LEN entries used.
  - LOSE = {9, 7, 5, 2}; first LOSE_LEN entries used.
- States: IDLE, NOTE, GAP, FINISH.
- IDLE:
  - On a rising clock edge with lose=1, select LOSE; else with win=1, select WIN.
  - Then go to NOTE with index=0 and tick counter=NOTE_TICKS-1.
  - Win and lose both high in the same cycle: LOSE wins.
- NOTE:
  - sound_freq_out = ROM[sel][index]; enable_sound = !mute; busy=1.
  - Counter decrements each cycle; at 0, go to GAP with counter=GAP_TICKS-1.
  - If GAP_TICKS=0, skip GAP and apply the GAP exit rule directly.
- GAP:
  - sound_freq_out=0; enable_sound=0; busy=1. Counter decrements.
  - At 0, if index==LEN-1, go to FINISH. Otherwise index+1 and go to NOTE with counter=NOTE_TICKS-1.
- FINISH:
  - One cycle: done=1, busy=0, enable_sound=0, sound_freq_out=0. Then IDLE.
- Outputs are registered. The first note appears on the cycle after the edge that sampled the strobe (latency 1).
- Retrigger rules while busy:
  - lose during a WIN melody: abort and restart as LOSE at index 0 in NOTE on the next cycle. No done pulse.
  - lose during a LOSE melody: ignored.
  - win while busy: ignored (dropped, not queued).
  - Strobes sampled during FINISH: ignored.
- Duration of an uninterrupted melody:
  - busy is high for LEN*(NOTE_TICKS+GAP_TICKS) cycles.
  - done follows on the next cycle.
- Widths:
  - Tick counter width = $clog2(max(NOTE_TICKS, GAP_TICKS, 2)).
  - Index is 2 bits and does not wrap past LEN-1.
- mute only gates enable_sound. Timing, busy and done are unaffected.

Test Plan:
- Reset, then a 1-cycle win pulse at cycle 10 (defaults):
  - Cycles 11-15: freq=5, enable=1.
  - Cycles 16-17: enable=0, freq=0.
  - Then notes 7, 9, 12 follow in the same pattern.
  - busy is high on cycles 11-38; done=1 on cycle 39 only.
- Win and lose both pulsed in the same cycle:
  - LOSE melody 9, 7, 5.
  - busy is high for 21 cycles, then a single done pulse.
- Win melody running; lose pulsed while note 7 is playing:
  - Next cycle freq=9 (LOSE index 0).
  - No done pulse before the LOSE melody completes.
- Lose melody running; lose and win pulses mid-melody:
  - Melody is unchanged; exactly one done pulse at the original time.
- mute=1 throughout a win melody:
  - enable_sound stays 0.
  - freq and busy timing match the first scenario.
- GAP_TICKS=0, NOTE_TICKS=1, WIN_LEN=2:
  - freq=5 then 7 on consecutive cycles, then done.
- resetN asserted low mid-note:
  - All outputs go to 0 immediately (asynchronously).
  - After release, block is IDLE; no done pulse.
